// File: rtl/mac_pause_tx_gate_if.sv
// -----------------------------------------------------------------------------
// mac_pause_tx_gate_if
// AXI-stream bundle used on both sides of the TX pause gate.
//   tdata/tkeep/tuser : payload, carried unchanged
//   tvalid/tready     : handshake
//   tlast             : end of frame
//   tid               : frame priority class (0-7)
// Modports:
//   master : drives payload and tvalid, receives tready
//   slave  : receives payload and tvalid, drives tready
// -----------------------------------------------------------------------------
interface mac_pause_tx_gate_if #(
  parameter int DATA_WIDTH = 32'sd8,
  parameter int KEEP_WIDTH = (DATA_WIDTH + 32'sd7) / 32'sd8,
  parameter int USER_WIDTH = 32'sd1
);
  logic [DATA_WIDTH-32'sd1:0] tdata;
  logic [KEEP_WIDTH-32'sd1:0] tkeep;
  logic                       tvalid;
  logic                       tready;
  logic                       tlast;
  logic [USER_WIDTH-32'sd1:0] tuser;
  logic [2:0]                 tid;

  modport master (
    output tdata, tkeep, tvalid, tlast, tuser, tid,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tvalid, tlast, tuser, tid,
    output tready
  );
endinterface

// File: rtl/mac_pause_tx_gate.sv
// -----------------------------------------------------------------------------
// mac_pause_tx_gate
// TX flow-control gate. Holds the head of the next frame (never a frame in
// progress) while a link-level or per-class pause is requested, and reports
// back through lfc_ack/pfc_ack when the link is quiet for that class so the
// pause-control stage may count down its quanta. Data crosses a one-stage
// registered skid buffer (output register + skid register).
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   s_axis (slave)       : TX input stream, tid sampled on the first beat
//   m_axis (master)      : TX output stream toward the framer
//   lfc_req / lfc_ack    : link pause request / link quiet
//   pfc_req / pfc_ack    : per-class pause request / class not transmitting
//   cfg_tx_gate_en       : enables holding frames
//   stat_tx_lfc_blocked  : head frame held by link pause
//   stat_tx_pfc_blocked  : head frame of class k held by class pause
//   stat_pause_cycles    : saturating count of cycles a head frame is held
// -----------------------------------------------------------------------------
module mac_pause_tx_gate #(
  parameter int DATA_WIDTH = 32'sd8,
  parameter int KEEP_WIDTH = (DATA_WIDTH + 32'sd7) / 32'sd8,
  parameter int USER_WIDTH = 32'sd1,
  parameter int PFC_ENABLE = 32'sd1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mac_pause_tx_gate_if.slave   s_axis,
  mac_pause_tx_gate_if.master  m_axis,
  input  logic                 lfc_req,
  output logic                 lfc_ack,
  input  logic [7:0]           pfc_req,
  output logic [7:0]           pfc_ack,
  input  logic                 cfg_tx_gate_en,
  output logic                 stat_tx_lfc_blocked,
  output logic [7:0]           stat_tx_pfc_blocked,
  output logic [31:0]          stat_pause_cycles
);

  // Beat layout inside the buffer registers: {tid, tlast, tuser, tkeep, tdata}
  localparam int  DATA_LSB = 32'sd0;
  localparam int  KEEP_LSB = DATA_LSB + DATA_WIDTH;
  localparam int  USER_LSB = KEEP_LSB + KEEP_WIDTH;
  localparam int  LAST_BIT = USER_LSB + USER_WIDTH;
  localparam int  TID_LSB  = LAST_BIT + 32'sd1;
  localparam int  BEAT_W   = TID_LSB + 32'sd3;
  localparam bit  PFC_ON   = (PFC_ENABLE != 32'sd0);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FRAME = 1'b1
  } state_t;

  state_t              state_r, state_s;
  logic [2:0]          cur_tid_r, cur_tid_s;
  logic [BEAT_W-1:0]   in_beat_s;
  logic [BEAT_W-1:0]   out_beat_r, out_beat_s;
  logic [BEAT_W-1:0]   skid_beat_r, skid_beat_s;
  logic                out_valid_r, out_valid_s;
  logic                skid_valid_r, skid_valid_s;
  logic                ready_r;
  logic                pfc_hit_s, block_s, s_tready_s, accept_s;
  logic                lfc_ack_r, lfc_ack_s;
  logic [7:0]          pfc_ack_r, pfc_ack_s;
  logic                lfc_blk_r, lfc_blk_s;
  logic [7:0]          pfc_blk_r, pfc_blk_s;
  logic [31:0]         pause_cnt_r;

  function automatic logic [2:0] beat_tid(input logic [BEAT_W-1:0] beat);
    return beat[TID_LSB +: 32'sd3];
  endfunction

  assign in_beat_s = {s_axis.tid, s_axis.tlast, s_axis.tuser, s_axis.tkeep, s_axis.tdata};

  assign m_axis.tdata  = out_beat_r[DATA_LSB +: DATA_WIDTH];
  assign m_axis.tkeep  = out_beat_r[KEEP_LSB +: KEEP_WIDTH];
  assign m_axis.tuser  = out_beat_r[USER_LSB +: USER_WIDTH];
  assign m_axis.tlast  = out_beat_r[LAST_BIT];
  assign m_axis.tid    = beat_tid(out_beat_r);
  assign m_axis.tvalid = out_valid_r;

  // The skid-empty flag is registered; blocking is combinational so a request
  // that drops releases the head beat in the same cycle.
  assign s_tready_s    = ready_r & ~block_s;
  assign s_axis.tready = s_tready_s;
  assign accept_s      = s_axis.tvalid & s_tready_s;

  assign lfc_ack             = lfc_ack_r;
  assign pfc_ack             = pfc_ack_r;
  assign stat_tx_lfc_blocked = lfc_blk_r;
  assign stat_tx_pfc_blocked = pfc_blk_r;
  assign stat_pause_cycles   = pause_cnt_r;

  // Block decision for the head beat; only frame boundaries are ever held.
  always_comb begin
    pfc_hit_s = 1'b0;
    if (PFC_ON) begin
      pfc_hit_s = pfc_req[s_axis.tid];
    end else begin
      pfc_hit_s = 1'b0;
    end
    block_s = cfg_tx_gate_en & s_axis.tvalid & (state_r == ST_IDLE) & (lfc_req | pfc_hit_s);
    lfc_blk_s = block_s & lfc_req;
    pfc_blk_s = 8'd0;
    if (block_s && pfc_hit_s) begin
      pfc_blk_s[s_axis.tid] = 1'b1;
    end else begin
      pfc_blk_s = 8'd0;
    end
  end

  // Frame tracker next state: opens on an accepted non-last head, closes on tlast.
  always_comb begin
    state_s   = state_r;
    cur_tid_s = cur_tid_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && !s_axis.tlast) begin
          state_s   = ST_FRAME;
          cur_tid_s = s_axis.tid;
        end else begin
          state_s   = ST_IDLE;
        end
      end
      ST_FRAME: begin
        if (accept_s && s_axis.tlast) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_FRAME;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Frame tracker state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      cur_tid_r <= 3'd0;
    end else begin
      state_r   <= state_s;
      cur_tid_r <= cur_tid_s;
    end
  end

  // Skid buffer next state: the skid register always drains first to keep order.
  always_comb begin
    out_valid_s  = out_valid_r;
    out_beat_s   = out_beat_r;
    skid_valid_s = skid_valid_r;
    skid_beat_s  = skid_beat_r;
    if (m_axis.tready || !out_valid_r) begin
      if (skid_valid_r) begin
        out_valid_s  = 1'b1;
        out_beat_s   = skid_beat_r;
        skid_valid_s = 1'b0;
      end else if (accept_s) begin
        out_valid_s  = 1'b1;
        out_beat_s   = in_beat_s;
      end else begin
        out_valid_s  = 1'b0;
      end
    end else begin
      if (accept_s) begin
        skid_valid_s = 1'b1;
        skid_beat_s  = in_beat_s;
      end else begin
        skid_valid_s = skid_valid_r;
      end
    end
  end

  // Skid buffer registers; reset drops any partial frame in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_r  <= 1'b0;
      skid_valid_r <= 1'b0;
      out_beat_r   <= {BEAT_W{1'b0}};
      skid_beat_r  <= {BEAT_W{1'b0}};
      ready_r      <= 1'b0;
    end else begin
      out_valid_r  <= out_valid_s;
      skid_valid_r <= skid_valid_s;
      out_beat_r   <= out_beat_s;
      skid_beat_r  <= skid_beat_s;
      ready_r      <= ~skid_valid_s;
    end
  end

  // Acknowledge next values: a class is quiet when it is neither open nor buffered.
  always_comb begin
    if (cfg_tx_gate_en) begin
      lfc_ack_s = lfc_req & (state_r == ST_IDLE) & ~out_valid_r & ~skid_valid_r;
    end else begin
      lfc_ack_s = lfc_req;
    end
    pfc_ack_s = 8'd0;
    for (int k = 32'sd0; k < 32'sd8; k++) begin
      if (!PFC_ON) begin
        pfc_ack_s[k] = 1'b0;
      end else if (!cfg_tx_gate_en) begin
        pfc_ack_s[k] = pfc_req[k];
      end else begin
        pfc_ack_s[k] = pfc_req[k]
                     & ~((state_r == ST_FRAME) && (cur_tid_r == k[2:0]))
                     & ~(out_valid_r && (beat_tid(out_beat_r) == k[2:0]))
                     & ~(skid_valid_r && (beat_tid(skid_beat_r) == k[2:0]));
      end
    end
  end

  // Registered acknowledges and block status.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfc_ack_r <= 1'b0;
      pfc_ack_r <= 8'd0;
      lfc_blk_r <= 1'b0;
      pfc_blk_r <= 8'd0;
    end else begin
      lfc_ack_r <= lfc_ack_s;
      pfc_ack_r <= pfc_ack_s;
      lfc_blk_r <= lfc_blk_s;
      pfc_blk_r <= pfc_blk_s;
    end
  end

  // Saturating count of cycles a head frame is held.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pause_cnt_r <= 32'd0;
    end else if (block_s && (pause_cnt_r != 32'hFFFF_FFFF)) begin
      pause_cnt_r <= pause_cnt_r + 32'd1;
    end else begin
      pause_cnt_r <= pause_cnt_r;
    end
  end

endmodule

// File: tb/tb_mac_pause_tx_gate.sv
// -----------------------------------------------------------------------------
// tb_mac_pause_tx_gate
// Self-checking bench for mac_pause_tx_gate. Inputs are driven 1 ns after the
// rising edge; a scoreboard samples every falling edge and predicts tready,
// acks, block status and pause count from frame-level rules (open frame,
// beats still buffered), and checks the output stream against a queue.
// -----------------------------------------------------------------------------
module tb_mac_pause_tx_gate;

  localparam int DW = 8;
  localparam int KW = 1;
  localparam int UW = 1;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
    logic [2:0]    tid;
    int            cyc;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lfc_req = 1'b0;
  logic        lfc_ack;
  logic [7:0]  pfc_req = 8'd0;
  logic [7:0]  pfc_ack;
  logic        cfg_tx_gate_en = 1'b1;
  logic        stat_tx_lfc_blocked;
  logic [7:0]  stat_tx_pfc_blocked;
  logic [31:0] stat_pause_cycles;

  mac_pause_tx_gate_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW)) s_if ();
  mac_pause_tx_gate_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW)) m_if ();

  mac_pause_tx_gate #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW), .PFC_ENABLE(1)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .s_axis              (s_if),
    .m_axis              (m_if),
    .lfc_req             (lfc_req),
    .lfc_ack             (lfc_ack),
    .pfc_req             (pfc_req),
    .pfc_ack             (pfc_ack),
    .cfg_tx_gate_en      (cfg_tx_gate_en),
    .stat_tx_lfc_blocked (stat_tx_lfc_blocked),
    .stat_tx_pfc_blocked (stat_tx_pfc_blocked),
    .stat_pause_cycles   (stat_pause_cycles)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model state
  beat_t       q[$];
  bit          m_in_frame = 1'b0;
  logic [2:0]  m_cur_tid = 3'd0;
  bit          m_rdy = 1'b0;
  bit          exp_valid = 1'b0;
  logic        exp_lfc_ack = 1'b0;
  logic [7:0]  exp_pfc_ack = 8'd0;
  logic        exp_lfc_blk = 1'b0;
  logic [7:0]  exp_pfc_blk = 8'd0;
  int unsigned exp_pause = 0;
  int          cyc = 0;
  bit          chk_lat = 1'b0;
  int          acc_cnt = 0;
  int          out_cnt = 0;

  task automatic scoreboard();
    logic  blk;
    logic  hit;
    bit    busy;
    beat_t b;
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_valid) begin
        checks++;
        if (lfc_ack !== exp_lfc_ack) begin
          errors++; $display("FAIL sb_lfc_ack cyc=%0d got=%b want=%b", cyc, lfc_ack, exp_lfc_ack);
        end
        checks++;
        if (pfc_ack !== exp_pfc_ack) begin
          errors++; $display("FAIL sb_pfc_ack cyc=%0d got=%h want=%h", cyc, pfc_ack, exp_pfc_ack);
        end
        checks++;
        if (stat_tx_lfc_blocked !== exp_lfc_blk) begin
          errors++; $display("FAIL sb_lfc_blocked cyc=%0d got=%b want=%b", cyc, stat_tx_lfc_blocked, exp_lfc_blk);
        end
        checks++;
        if (stat_tx_pfc_blocked !== exp_pfc_blk) begin
          errors++; $display("FAIL sb_pfc_blocked cyc=%0d got=%h want=%h", cyc, stat_tx_pfc_blocked, exp_pfc_blk);
        end
        checks++;
        if (stat_pause_cycles !== 32'(exp_pause)) begin
          errors++; $display("FAIL sb_pause_cycles cyc=%0d got=%0d want=%0d", cyc, stat_pause_cycles, exp_pause);
        end
      end
      if (rst_n !== 1'b1) begin
        q.delete();
        m_in_frame  = 1'b0;
        m_rdy       = 1'b0;
        exp_lfc_ack = 1'b0;
        exp_pfc_ack = 8'd0;
        exp_lfc_blk = 1'b0;
        exp_pfc_blk = 8'd0;
        exp_pause   = 0;
        exp_valid   = 1'b1;
      end else begin
        hit = lfc_req | pfc_req[s_if.tid];
        blk = cfg_tx_gate_en & s_if.tvalid & ~m_in_frame & hit;
        checks++;
        if (s_if.tready !== (m_rdy & ~blk)) begin
          errors++; $display("FAIL sb_s_tready cyc=%0d got=%b want=%b", cyc, s_if.tready, m_rdy & ~blk);
        end
        if (cfg_tx_gate_en) exp_lfc_ack = lfc_req & ~m_in_frame & (q.size() == 0);
        else                exp_lfc_ack = lfc_req;
        for (int k = 0; k < 8; k++) begin
          busy = m_in_frame && (int'(m_cur_tid) == k);
          for (int j = 0; j < q.size(); j++) if (int'(q[j].tid) == k) busy = 1'b1;
          exp_pfc_ack[k] = cfg_tx_gate_en ? (pfc_req[k] & ~busy) : pfc_req[k];
        end
        exp_lfc_blk = blk & lfc_req;
        exp_pfc_blk = 8'd0;
        if (blk && pfc_req[s_if.tid]) exp_pfc_blk[s_if.tid] = 1'b1;
        if (blk) exp_pause++;
        if (m_if.tvalid && m_if.tready) begin
          checks++;
          if (q.size() == 0) begin
            errors++; $display("FAIL sb_extra_beat cyc=%0d got=%h want=none", cyc, m_if.tdata);
          end else begin
            b = q.pop_front();
            out_cnt++;
            if (m_if.tdata !== b.data || m_if.tkeep !== b.keep || m_if.tuser !== b.user ||
                m_if.tlast !== b.last || m_if.tid !== b.tid) begin
              errors++;
              $display("FAIL sb_beat cyc=%0d got=%h/%b/%b/%b/%0d want=%h/%b/%b/%b/%0d", cyc,
                       m_if.tdata, m_if.tkeep, m_if.tuser, m_if.tlast, m_if.tid,
                       b.data, b.keep, b.user, b.last, b.tid);
            end
            if (chk_lat && (cyc - b.cyc != 1)) begin
              errors++; $display("FAIL sb_latency cyc=%0d got=%0d want=1", cyc, cyc - b.cyc);
            end
          end
        end
        if (s_if.tvalid && s_if.tready) begin
          q.push_back('{s_if.tdata, s_if.tkeep, s_if.tuser, s_if.tlast, s_if.tid, cyc});
          acc_cnt++;
          if (s_if.tlast) m_in_frame = 1'b0;
          else if (!m_in_frame) begin
            m_in_frame = 1'b1;
            m_cur_tid  = s_if.tid;
          end
        end
        m_rdy = (q.size() < 2);
      end
    end
  endtask

  task automatic idle(input int n);
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input logic [2:0] tid, input int len, input int lfc_at,
                            input bit drop_last, output int stalls);
    bit acc;
    int n;
    stalls = 0;
    for (int i = 0; i < len; i++) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = DW'($urandom);
      s_if.tkeep  = KW'($urandom);
      s_if.tuser  = UW'($urandom);
      s_if.tlast  = (i == len - 1) && !drop_last;
      s_if.tid    = tid;
      if (i == lfc_at) lfc_req = 1'b1;
      acc = 1'b0;
      n   = 0;
      while (!acc) begin
        @(negedge clk);
        acc = s_if.tvalid & s_if.tready;
        @(posedge clk); #1;
        if (!acc) begin
          stalls++;
          n++;
          if (n > 5000) begin
            checks++; errors++;
            $display("FAIL accept_timeout got=%0d cycles want<=5000", n);
            acc = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) begin @(posedge clk); end
    #1;
    checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL rst_m_tvalid got=%b want=0", m_if.tvalid); end
    checks++; if (s_if.tready !== 1'b0) begin errors++; $display("FAIL rst_s_tready got=%b want=0", s_if.tready); end
    checks++; if ({lfc_ack, pfc_ack} !== 9'd0) begin errors++; $display("FAIL rst_acks got=%h want=0", {lfc_ack, pfc_ack}); end
    checks++;
    if ({stat_tx_lfc_blocked, stat_tx_pfc_blocked, stat_pause_cycles} !== 41'd0) begin
      errors++; $display("FAIL rst_stats got=%h want=0", {stat_tx_lfc_blocked, stat_tx_pfc_blocked, stat_pause_cycles});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (s_if.tready !== 1'b1) begin errors++; $display("FAIL rst_release_tready got=%b want=1", s_if.tready); end
  endtask

  task automatic test_pass_through();
    int st, tot, o0;
    tot = 0;
    o0 = out_cnt;
    m_if.tready = 1'b1;
    chk_lat = 1'b1;
    for (int f = 0; f < 3; f++) begin
      send_frame(3'($urandom_range(0, 7)), 64, -1, 1'b0, st);
      tot += st;
    end
    idle(4);
    chk_lat = 1'b0;
    checks++; if (tot !== 0) begin errors++; $display("FAIL pt_stalls got=%0d want=0", tot); end
    checks++; if (out_cnt - o0 !== 192) begin errors++; $display("FAIL pt_beats got=%0d want=192", out_cnt - o0); end
    checks++; if ({lfc_ack, pfc_ack} !== 9'd0) begin errors++; $display("FAIL pt_acks got=%h want=0", {lfc_ack, pfc_ack}); end
  endtask

  task automatic test_lfc_mid_frame();
    int st1, st2;
    logic [31:0] p0;
    send_frame(3'd5, 64, 10, 1'b0, st1);
    checks++; if (st1 !== 0) begin errors++; $display("FAIL lfc_frame_stalled got=%0d want=0", st1); end
    p0 = stat_pause_cycles;
    fork
      send_frame(3'd1, 8, -1, 1'b0, st2);
      begin
        repeat (6) begin @(posedge clk); end
        #1;
        checks++; if (lfc_ack !== 1'b1) begin errors++; $display("FAIL lfc_ack_quiet got=%b want=1", lfc_ack); end
        checks++; if (stat_tx_lfc_blocked !== 1'b1) begin errors++; $display("FAIL lfc_blocked got=%b want=1", stat_tx_lfc_blocked); end
        repeat (14) begin @(posedge clk); end
        #1;
        lfc_req = 1'b0;
      end
    join
    idle(4);
    checks++; if (st2 !== 20) begin errors++; $display("FAIL lfc_hold_len got=%0d want=20", st2); end
    checks++; if (stat_pause_cycles - p0 !== 32'd20) begin errors++; $display("FAIL lfc_pause_cycles got=%0d want=20", stat_pause_cycles - p0); end
  endtask

  task automatic test_pfc();
    int st;
    pfc_req = 8'h04;
    idle(3);
    fork
      send_frame(3'd2, 8, -1, 1'b0, st);
      begin
        repeat (5) begin @(posedge clk); end
        #1;
        checks++; if (stat_tx_pfc_blocked !== 8'h04) begin errors++; $display("FAIL pfc_blocked got=%h want=04", stat_tx_pfc_blocked); end
        checks++; if (pfc_ack !== 8'h04) begin errors++; $display("FAIL pfc_ack got=%h want=04", pfc_ack); end
        repeat (5) begin @(posedge clk); end
        #1;
        pfc_req = 8'h00;
      end
    join
    checks++; if (st !== 10) begin errors++; $display("FAIL pfc_hold_len got=%0d want=10", st); end
    idle(4);
    pfc_req = 8'h04;
    send_frame(3'd3, 8, -1, 1'b0, st);
    checks++; if (st !== 0) begin errors++; $display("FAIL pfc_other_class got=%0d want=0", st); end
    idle(4);
    checks++; if (pfc_ack !== 8'h04) begin errors++; $display("FAIL pfc_ack_after got=%h want=04", pfc_ack); end
    pfc_req = 8'h00;
    idle(2);
  endtask

  task automatic test_gate_disabled();
    int st, tot;
    cfg_tx_gate_en = 1'b0;
    lfc_req = 1'b1;
    @(posedge clk); #1;
    checks++; if (lfc_ack !== 1'b1) begin errors++; $display("FAIL gd_lfc_ack got=%b want=1", lfc_ack); end
    tot = 0;
    for (int f = 0; f < 2; f++) begin
      send_frame(3'($urandom_range(0, 7)), 16, -1, 1'b0, st);
      tot += st;
    end
    idle(2);
    checks++; if (tot !== 0) begin errors++; $display("FAIL gd_stalls got=%0d want=0", tot); end
    lfc_req = 1'b0;
    @(posedge clk); #1;
    checks++; if (lfc_ack !== 1'b0) begin errors++; $display("FAIL gd_lfc_ack_fall got=%b want=0", lfc_ack); end
    cfg_tx_gate_en = 1'b1;
    idle(2);
  endtask

  task automatic test_backpressure();
    bit done;
    int st, total, a0, o0;
    done = 1'b0;
    total = 0;
    a0 = acc_cnt;
    o0 = out_cnt;
    fork
      begin
        for (int f = 0; f < 100; f++) begin
          int len;
          len = $urandom_range(1, 8);
          total += len;
          send_frame(3'($urandom_range(0, 7)), len, -1, 1'b0, st);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          m_if.tready = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 15) == 0) lfc_req = ~lfc_req;
          if ($urandom_range(0, 15) == 0) pfc_req = 8'($urandom) & 8'($urandom);
        end
      end
    join
    lfc_req = 1'b0;
    pfc_req = 8'd0;
    m_if.tready = 1'b1;
    idle(10);
    checks++; if (acc_cnt - a0 !== total) begin errors++; $display("FAIL bp_accepted got=%0d want=%0d", acc_cnt - a0, total); end
    checks++; if (out_cnt - o0 !== total) begin errors++; $display("FAIL bp_delivered got=%0d want=%0d", out_cnt - o0, total); end
    checks++; if (q.size() !== 0) begin errors++; $display("FAIL bp_leftover got=%0d want=0", q.size()); end
  endtask

  task automatic test_reset_mid_frame();
    int st, o0;
    m_if.tready = 1'b1;
    lfc_req = 1'b1;
    idle(2);
    lfc_req = 1'b0;
    send_frame(3'd4, 5, -1, 1'b1, st);
    s_if.tvalid = 1'b1;
    s_if.tdata  = 8'hA5;
    s_if.tlast  = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    s_if.tvalid = 1'b0;
    checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL rmf_m_tvalid got=%b want=0", m_if.tvalid); end
    checks++; if (s_if.tready !== 1'b0) begin errors++; $display("FAIL rmf_s_tready got=%b want=0", s_if.tready); end
    checks++; if (stat_pause_cycles !== 32'd0) begin errors++; $display("FAIL rmf_pause got=%0d want=0", stat_pause_cycles); end
    idle(2);
    o0 = out_cnt;
    send_frame(3'd6, 8, -1, 1'b0, st);
    idle(4);
    checks++; if (st !== 0) begin errors++; $display("FAIL rmf_next_stalls got=%0d want=0", st); end
    checks++; if (out_cnt - o0 !== 8) begin errors++; $display("FAIL rmf_next_beats got=%0d want=8", out_cnt - o0); end
  endtask

  initial begin
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tkeep  = '0;
    s_if.tuser  = '0;
    s_if.tlast  = 1'b0;
    s_if.tid    = 3'd0;
    m_if.tready = 1'b1;
    fork
      scoreboard();
    join_none
    test_reset();
    test_pass_through();
    test_lfc_mid_frame();
    test_pfc();
    test_gate_disabled();
    test_backpressure();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
